// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity, one stop bit.
// Define UART_TX_PARITY_EN to compile in the parity bit (sense chosen by PARITY_ODD).
module uart_tx #(
  parameter int CLKS_PER_BIT = 5208,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data_in,
  output logic       tx_data_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t            state_reg;
  logic [BAUD_W-1:0] baud_reg;
  logic [2:0]        bit_cnt_reg;
  logic [7:0]        shift_reg;
  logic              bit_end;

`ifdef UART_TX_PARITY_EN
  logic              parity_reg;
`else
  // PARITY_ODD has no effect when the parity stage is not built.
  if (PARITY_ODD != 1'b0) begin : g_parity_sense_unused
  end
`endif

  assign bit_end = (baud_reg == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      baud_reg    <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
      tx_data_out <= 1'b1;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg  <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          baud_reg <= '0;
          if (tx_start) begin
            state_reg   <= START;
            shift_reg   <= tx_data_in;
            tx_data_out <= 1'b0;
            tx_busy     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_reg  <= (^tx_data_in) ^ PARITY_ODD;
`endif
          end
        end

        START: begin
          if (bit_end) begin
            baud_reg    <= '0;
            bit_cnt_reg <= '0;
            state_reg   <= DATA;
            tx_data_out <= shift_reg[0];
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_reg  <= '0;
            shift_reg <= shift_reg >> 1;
            if (bit_cnt_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_reg   <= PARITY;
              tx_data_out <= parity_reg;
`else
              state_reg   <= STOP;
              tx_data_out <= 1'b1;
`endif
            end else begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              // Line is registered, so present the bit that becomes shift[0] next.
              tx_data_out <= shift_reg[1];
            end
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud_reg    <= '0;
            state_reg   <= STOP;
            tx_data_out <= 1'b1;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            baud_reg  <= '0;
            state_reg <= IDLE;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b1;
          end else begin
            baud_reg <= baud_reg + 1'b1;
          end
        end

        default: begin
          state_reg   <= IDLE;
          baud_reg    <= '0;
          tx_data_out <= 1'b1;
          tx_busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model plus a behavioural
// mid-bit sampling receiver on a second instance (CLKS_PER_BIT=16, odd parity).
module tb_uart_tx;
  localparam int CPB    = 4;
  localparam int CPB_LB = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start4 = 1'b0;
  logic [7:0] data4 = 8'h00;
  logic       line4, busy4, done4;
  logic       start_lb = 1'b0;
  logic [7:0] data_lb = 8'h00;
  logic       line_lb, busy_lb, done_lb;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .tx_start(start4), .tx_data_in(data4),
    .tx_data_out(line4), .tx_busy(busy4), .tx_done(done4)
  );

  uart_tx #(.CLKS_PER_BIT(CPB_LB), .PARITY_ODD(1'b1)) dut_lb (
    .clk(clk), .rst(rst), .tx_start(start_lb), .tx_data_in(data_lb),
    .tx_data_out(line_lb), .tx_busy(busy_lb), .tx_done(done_lb)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Expected line levels, index 0 = start bit, last index = stop bit.
  function automatic logic [10:0] frame_bits(input logic [7:0] b, input bit odd);
    logic [10:0] f;
    f    = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[i+1] = b[i];
`ifdef UART_TX_PARITY_EN
    f[9] = logic'(($countones(b) % 2) != 0) ^ odd;
`else
    if (odd) f[9] = 1'b1;
`endif
    return f;
  endfunction

  // Called at a negedge; returns at the negedge of the cycle after acceptance.
  task automatic launch(input logic [7:0] b);
    start4 = 1'b1;
    data4  = b;
    tick();
    start4 = 1'b0;
    data4  = 8'($urandom);
  endtask

  task automatic check_frame(input logic [7:0] b, input int inject_at,
                             input bit chain, input logic [7:0] next_b);
    logic [10:0] f;
    int good;
    int busy_cnt;
    int done_cnt;
    int cyc;
    f        = frame_bits(b, 1'b0);
    busy_cnt = 0;
    done_cnt = 0;
    cyc      = 0;
    for (int k = 0; k < NBITS; k++) begin
      good = 0;
      for (int c = 0; c < CPB; c++) begin
        if (line4 === f[k]) good++;
        if (busy4 === 1'b1) busy_cnt++;
        if (done4 !== 1'b0) done_cnt++;
        if (cyc == inject_at) begin
          start4 = 1'b1;
          data4  = 8'hFF;
        end else if (cyc == inject_at + 1) begin
          start4 = 1'b0;
        end
        if (chain && k == NBITS - 1 && c == CPB - 1) begin
          start4 = 1'b1;
          data4  = next_b;
        end
        cyc++;
        tick();
      end
      check($sformatf("bit%0d_of_%02h", k, b), good, CPB);
    end
    check("busy_len", busy_cnt, NBITS * CPB);
    check("done_in_frame", done_cnt, 0);
    check("done_pulse", done4, 1'b1);
    check("busy_after", busy4, 1'b0);
    check("line_idle", line4, 1'b1);
    tick();
    if (chain) begin
      start4 = 1'b0;
      data4  = 8'($urandom);
    end else begin
      check("done_cleared", done4, 1'b0);
    end
    $display("frame 0x%02h checked on %0d-bit line", b, NBITS);
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    int bad;
    bad = 0;
    for (int i = 0; i < cycles; i++) begin
      if (busy4 !== 1'b0 || done4 !== 1'b0 || line4 !== 1'b1) bad++;
      tick();
    end
    check(tag, bad, 0);
  endtask

  task automatic loopback(input logic [7:0] b);
    logic [7:0] got;
    int w;
    got      = 8'h00;
    start_lb = 1'b1;
    data_lb  = b;
    tick();
    start_lb = 1'b0;
    data_lb  = 8'($urandom);
    w = 0;
    while (line_lb !== 1'b0 && w < 64) begin
      tick();
      w++;
    end
    check("lb_start_seen", line_lb, 1'b0);
    repeat (CPB_LB / 2) tick();
    check("lb_start_mid", line_lb, 1'b0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB_LB) tick();
      got[i] = line_lb;
    end
`ifdef UART_TX_PARITY_EN
    repeat (CPB_LB) tick();
    check("lb_parity", line_lb, (^got) ^ 1'b1);
`endif
    repeat (CPB_LB) tick();
    check("lb_stop", line_lb, 1'b1);
    check("lb_byte", got, b);
    w = 0;
    while (busy_lb !== 1'b0 && w < 64) begin
      tick();
      w++;
    end
    check("lb_busy_drop", busy_lb, 1'b0);
    tick();
    $display("loopback sent 0x%02h received 0x%02h", b, got);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] dir [3];
    dir = '{8'h00, 8'hFF, 8'h81};

    rst = 1'b1;
    repeat (3) tick();
    check("rst_line", line4, 1'b1);
    check("rst_busy", busy4, 1'b0);
    check("rst_done", done4, 1'b0);
    check("rst_line_lb", line_lb, 1'b1);
    rst = 1'b0;
    tick();

    launch(8'hA5);
    check_frame(8'hA5, -1, 1'b0, 8'h00);
    launch(8'h07);
    check_frame(8'h07, -1, 1'b0, 8'h00);

    launch(8'h3C);
    check_frame(8'h3C, -1, 1'b1, 8'hC3);
    check_frame(8'hC3, -1, 1'b0, 8'h00);

    launch(8'h00);
    check_frame(8'h00, 3 * CPB + 2, 1'b0, 8'h00);
    check_quiet("ignored_start_quiet", 2 * CPB);

    b = 8'($urandom);
    b[3] = ~b[3] ^ b[2];
    launch(b);
    repeat (4 * CPB) tick();
    check("pre_reset_bit3", line4, b[3]);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_line", line4, 1'b1);
    check("midrst_busy", busy4, 1'b0);
    check("midrst_done", done4, 1'b0);
    check_quiet("midrst_quiet", 3 * CPB);
    $display("frame 0x%02h aborted by reset", b);
    launch(8'h55);
    check_frame(8'h55, -1, 1'b0, 8'h00);

    start4 = 1'b1;
    data4  = 8'hAA;
    rst    = 1'b1;
    tick();
    rst    = 1'b0;
    start4 = 1'b0;
    check("rst_vs_start_busy", busy4, 1'b0);
    check("rst_vs_start_line", line4, 1'b1);
    tick();
    check("rst_vs_start_busy2", busy4, 1'b0);

    for (int n = 0; n < 12; n++) begin
      repeat ($urandom_range(0, 3)) tick();
      b = 8'($urandom);
      launch(b);
      check_frame(b, -1, 1'b0, 8'h00);
    end

    for (int n = 0; n < 3; n++) loopback(dir[n]);
    for (int n = 0; n < 4; n++) loopback(8'($urandom));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
